// File: rtl/audio_axi_pkg.sv
// Shared register map, bit positions, response codes and FSM encodings
// for the audio sample AXI4-Lite slave.
package audio_axi_pkg;

  localparam logic [1:0] REG_ID     = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_FLUSH_BIT    = 1;
  localparam int CTRL_THRESH_LSB   = 8;
  localparam int STATUS_EMPTY_BIT  = 16;
  localparam int STATUS_FULL_BIT   = 17;
  localparam int STATUS_OVF_BIT    = 18;
  localparam int STATUS_UNF_BIT    = 19;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;
  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;

  function automatic logic [31:0] build_status(input logic [8:0] level,
                                               input logic empty,
                                               input logic full,
                                               input logic overflow,
                                               input logic underflow);
    logic [31:0] word;
    word = 32'd0;
    word[8:0] = level;
    word[STATUS_EMPTY_BIT] = empty;
    word[STATUS_FULL_BIT]  = full;
    word[STATUS_OVF_BIT]   = overflow;
    word[STATUS_UNF_BIT]   = underflow;
    return word;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with extra-MSB pointers; head is visible on dout
// so the register read path can capture it in the pop cycle.
module audio_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full
);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = wr_ptr_reg - rd_ptr_reg;

  // A simultaneous pop frees the slot a push into a full FIFO needs.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/audio_sample_axi_slave.sv
// AXI4-Lite slave exposing a captured-audio FIFO as a pop-on-read DATA
// register, plus ID/CTRL/STATUS registers and a level-threshold interrupt.
module audio_sample_axi_slave
  import audio_axi_pkg::*;
#(
  parameter int          C_S00_AXI_DATA_WIDTH = 32,
  parameter int          C_S00_AXI_ADDR_WIDTH = 4,
  parameter int          SAMPLE_WIDTH         = 24,
  parameter int          FIFO_DEPTH           = 16,
  parameter logic [31:0] ID_VALUE             = 32'h0012_3456
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic                              sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]           sample_data,
  output logic                              sample_ready,
  output logic                              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  rd_state_t                 rd_state_reg;
  wr_state_t                 wr_state_reg;
  logic                      arready_reg;
  logic                      rvalid_reg;
  logic [31:0]               rdata_reg;
  logic                      awready_reg;
  logic                      wready_reg;
  logic                      bvalid_reg;

  logic                      enable_reg;
  logic [7:0]                thresh_reg;
  logic                      overflow_reg;
  logic                      underflow_reg;
  logic                      irq_reg;

  logic                      rd_hs;
  logic                      wr_hs;
  logic [1:0]                rd_idx;
  logic [1:0]                wr_idx;
  logic [31:0]               wmask;
  logic [31:0]               ctrl_word;
  logic [31:0]               ctrl_next;
  logic                      ctrl_wr;
  logic                      flush;
  logic                      overflow_clr;
  logic                      underflow_clr;
  logic                      overflow_set;
  logic                      underflow_set;
  logic                      irq_next;
  logic [31:0]               read_word;
  logic [31:0]               sample_ext;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [SAMPLE_WIDTH-1:0]   fifo_dout;
  logic [AW:0]               fifo_level;
  logic [8:0]                level_ext;
  logic                      fifo_empty;
  logic                      fifo_full;

  assign rd_idx = s00_axi_araddr[3:2];
  assign wr_idx = s00_axi_awaddr[3:2];
  assign rd_hs  = arready_reg & s00_axi_arvalid;
  assign wr_hs  = awready_reg & wready_reg & s00_axi_awvalid & s00_axi_wvalid;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{s00_axi_wstrb[gi]}};
    end
  endgenerate

  // ---------------- FIFO ----------------
  assign fifo_push = sample_valid & enable_reg;
  assign fifo_pop  = rd_hs & (rd_idx == REG_DATA) & ~fifo_empty;

  audio_sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (sample_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign level_ext    = 9'(fifo_level);
  assign sample_ext   = 32'($signed(fifo_dout));
  assign sample_ready = ~fifo_full;

  // ---------------- Register decode ----------------
  assign ctrl_word = {16'd0, thresh_reg, 7'd0, enable_reg};
  assign ctrl_next = (ctrl_word & ~wmask) | (s00_axi_wdata & wmask);
  assign ctrl_wr   = wr_hs & (wr_idx == REG_CTRL);
  assign flush     = ctrl_wr & wmask[CTRL_FLUSH_BIT] & s00_axi_wdata[CTRL_FLUSH_BIT];

  assign overflow_clr  = wr_hs & (wr_idx == REG_STATUS) &
                         wmask[STATUS_OVF_BIT] & s00_axi_wdata[STATUS_OVF_BIT];
  assign underflow_clr = wr_hs & (wr_idx == REG_STATUS) &
                         wmask[STATUS_UNF_BIT] & s00_axi_wdata[STATUS_UNF_BIT];

  // A dropped sample only counts when neither a pop nor a flush makes room.
  assign overflow_set  = fifo_push & fifo_full & ~fifo_pop & ~flush;
  assign underflow_set = rd_hs & (rd_idx == REG_DATA) & fifo_empty;

  assign irq_next = (enable_reg && (thresh_reg != 8'd0) &&
                     (level_ext >= {1'b0, thresh_reg})) || overflow_reg;

  always_comb begin
    read_word = 32'd0;
    case (rd_idx)
      REG_ID:     read_word = ID_VALUE;
      REG_CTRL:   read_word = ctrl_word;
      REG_STATUS: read_word = build_status(level_ext, fifo_empty, fifo_full,
                                           overflow_reg, underflow_reg);
      REG_DATA:   read_word = fifo_empty ? 32'd0 : sample_ext;
      default:    read_word = 32'd0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      enable_reg    <= 1'b0;
      thresh_reg    <= 8'd0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable_reg <= ctrl_next[CTRL_ENABLE_BIT];
        thresh_reg <= ctrl_next[CTRL_THRESH_LSB +: 8];
      end
      // A new event in the same cycle as a W1C wins, so it is never lost.
      overflow_reg  <= overflow_set  | (overflow_reg  & ~overflow_clr);
      underflow_reg <= underflow_set | (underflow_reg & ~underflow_clr);
      irq_reg       <= irq_next;
    end
  end

  // ---------------- Read channel FSM ----------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= 32'd0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (rd_hs) begin
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b1;
            rdata_reg    <= read_word;
            rd_state_reg <= R_RESP;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_RESP: begin
          if (s00_axi_rready) begin
            rvalid_reg   <= 1'b0;
            arready_reg  <= 1'b1;
            rd_state_reg <= R_IDLE;
          end
        end
        default: begin
          rd_state_reg <= R_IDLE;
          arready_reg  <= 1'b0;
          rvalid_reg   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- Write channel FSM ----------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_state_reg <= W_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (wr_hs) begin
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b1;
            wr_state_reg <= W_RESP;
          end else if (s00_axi_awvalid && s00_axi_wvalid && !bvalid_reg && !awready_reg) begin
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end else begin
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            bvalid_reg   <= 1'b0;
            wr_state_reg <= W_IDLE;
          end
        end
        default: begin
          wr_state_reg <= W_IDLE;
          awready_reg  <= 1'b0;
          wready_reg   <= 1'b0;
          bvalid_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign s00_axi_arready = arready_reg;
  assign s00_axi_rvalid  = rvalid_reg;
  assign s00_axi_rdata   = rdata_reg;
  assign s00_axi_rresp   = RESP_OKAY;
  assign s00_axi_awready = awready_reg;
  assign s00_axi_wready  = wready_reg;
  assign s00_axi_bvalid  = bvalid_reg;
  assign s00_axi_bresp   = RESP_OKAY;
  assign irq             = irq_reg;

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], ctrl_next[31:16], ctrl_next[7:1]};

endmodule

// File: tb/tb_audio_sample_axi_slave.sv
// Directed bench for the audio sample AXI slave: a vector table for the
// register/FIFO flow plus hand sequences for the multi-cycle corner cases.
module tb_audio_sample_axi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_data = '0;
  logic        sample_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  audio_sample_axi_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .sample_ready    (sample_ready),
    .irq             (irq)
  );

  typedef enum int {OP_WR, OP_RD, OP_PUSH, OP_IRQ} op_t;
  typedef struct {
    op_t         op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input op_t op, input logic [3:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [31:0] exp, input string name);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.strb = strb; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake timed out, got no ready, expected ready within 20 cycles", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name,
                          input int hold, input bit push_hs, input logic [23:0] pv);
    int k;
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (arready) break;
      tick();
    end
    if (!arready) begin
      timeout({name, "_ar"});
      arvalid = 1'b0;
      return;
    end
    check({name, "_rvalid_pre"}, 32'(rvalid), 32'd0);
    if (push_hs) begin
      sample_valid = 1'b1;
      sample_data  = pv;
    end
    tick();
    arvalid      = 1'b0;
    sample_valid = 1'b0;
    check({name, "_rvalid"}, 32'(rvalid), 32'd1);
    check(name, rdata, exp);
    check({name, "_rresp"}, 32'(rresp), 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, "_hold_rvalid"}, 32'(rvalid), 32'd1);
      check({name, "_hold_rdata"}, rdata, exp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({name, "_rvalid_clr"}, 32'(rvalid), 32'd0);
    $display("rd  addr=0x%0h data=0x%08h exp=0x%08h (%s)", addr, rdata, exp, name);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input string name, input int aw_lead, input bit push_hs,
                           input logic [23:0] pv);
    int k;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      tick();
      check({name, "_awready_wait"}, 32'(awready), 32'd0);
    end
    wvalid = 1'b1;
    for (k = 0; k < 20; k++) begin
      if (awready) break;
      tick();
    end
    if (!awready) begin
      timeout({name, "_aw"});
      awvalid = 1'b0;
      wvalid  = 1'b0;
      return;
    end
    check({name, "_wready"}, 32'(wready), 32'd1);
    if (push_hs) begin
      sample_valid = 1'b1;
      sample_data  = pv;
    end
    tick();
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    sample_valid = 1'b0;
    check({name, "_bvalid"}, 32'(bvalid), 32'd1);
    check({name, "_bresp"}, 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({name, "_bvalid_clr"}, 32'(bvalid), 32'd0);
    tick();
    check({name, "_no_second_b"}, 32'(bvalid), 32'd0);
    $display("wr  addr=0x%0h data=0x%08h strb=0x%0h (%s)", addr, data, strb, name);
  endtask

  task automatic push(input logic [23:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
    $display("push data=0x%06h", d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main register/FIFO flow
    add(OP_RD,   4'h0, 32'h0,        4'h0, 32'h0012_3456, "id");
    add(OP_RD,   4'h4, 32'h0,        4'h0, 32'h0000_0000, "ctrl_rst");
    add(OP_RD,   4'h8, 32'h0,        4'h0, 32'h0001_0000, "status_rst");
    add(OP_WR,   4'h0, 32'hFFFF_FFFF, 4'hF, 32'h0,         "wr_id");
    add(OP_RD,   4'h0, 32'h0,        4'h0, 32'h0012_3456, "id_ro");
    add(OP_WR,   4'h4, 32'h0000_0401, 4'hF, 32'h0,         "wr_ctrl");
    add(OP_RD,   4'h4, 32'h0,        4'h0, 32'h0000_0401, "ctrl");
    add(OP_WR,   4'h4, 32'h0000_0800, 4'h1, 32'h0,         "wr_ctrl_lane0");
    add(OP_RD,   4'h4, 32'h0,        4'h0, 32'h0000_0400, "ctrl_lane0");
    add(OP_PUSH, 4'h0, 32'h0000_0005, 4'h0, 32'h0,         "push_disabled");
    add(OP_RD,   4'h8, 32'h0,        4'h0, 32'h0001_0000, "status_disabled");
    add(OP_WR,   4'h4, 32'h0000_0401, 4'hF, 32'h0,         "wr_ctrl_en");
    add(OP_PUSH, 4'h0, 32'h007F_FFFF, 4'h0, 32'h0,         "p0");
    add(OP_PUSH, 4'h0, 32'h0080_0000, 4'h0, 32'h0,         "p1");
    add(OP_PUSH, 4'h0, 32'h0000_0001, 4'h0, 32'h0,         "p2");
    add(OP_PUSH, 4'h0, 32'h0000_0002, 4'h0, 32'h0,         "p3");
    add(OP_IRQ,  4'h0, 32'h0,        4'h0, 32'h1,         "irq_thresh");
    add(OP_RD,   4'h8, 32'h0,        4'h0, 32'h0000_0004, "status_lvl4");
    add(OP_RD,   4'hC, 32'h0,        4'h0, 32'h007F_FFFF, "data0");
    add(OP_RD,   4'hC, 32'h0,        4'h0, 32'hFF80_0000, "data1");
    add(OP_RD,   4'hC, 32'h0,        4'h0, 32'h0000_0001, "data2");
    add(OP_RD,   4'hC, 32'h0,        4'h0, 32'h0000_0002, "data3");
    add(OP_RD,   4'h8, 32'h0,        4'h0, 32'h0001_0000, "status_drained");
    add(OP_IRQ,  4'h0, 32'h0,        4'h0, 32'h0,         "irq_drained");

    // Reset state
    repeat (3) tick();
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_irq",     32'(irq),     32'd0);
    check("rst_sample_ready", 32'(sample_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:   axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].name, 0, 1'b0, 24'h0);
        OP_RD:   axi_read(vecs[i].addr, vecs[i].exp, vecs[i].name, 0, 1'b0, 24'h0);
        OP_PUSH: push(vecs[i].data[23:0]);
        OP_IRQ: begin
          repeat (2) tick();
          check(vecs[i].name, 32'(irq), vecs[i].exp);
          $display("irq value=%0b exp=%0b (%s)", irq, vecs[i].exp[0], vecs[i].name);
        end
        default: ;
      endcase
    end

    // Overflow: 17 pushes into an empty 16-deep FIFO
    for (int i = 0; i < 17; i++) push(24'(i + 1));
    check("sample_ready_full", 32'(sample_ready), 32'd0);
    repeat (2) tick();
    check("irq_overflow", 32'(irq), 32'd1);
    axi_read(4'h8, 32'h0006_0010, "status_ovf", 0, 1'b0, 24'h0);
    axi_write(4'h8, 32'h0004_0000, 4'hF, "w1c_ovf", 0, 1'b0, 24'h0);
    axi_read(4'h8, 32'h0002_0010, "status_ovf_clr", 0, 1'b0, 24'h0);

    // Full FIFO: push in the DATA pop cycle succeeds, no overflow
    axi_read(4'hC, 32'h0000_0001, "data_pop_push", 0, 1'b1, 24'h000099);
    axi_read(4'h8, 32'h0002_0010, "status_pop_push", 0, 1'b0, 24'h0);

    // Flush beats a simultaneous push
    axi_write(4'h4, 32'h0000_0003, 4'hF, "wr_flush", 0, 1'b1, 24'h000055);
    axi_read(4'h8, 32'h0001_0000, "status_flush", 0, 1'b0, 24'h0);
    axi_read(4'h4, 32'h0000_0001, "ctrl_flush", 0, 1'b0, 24'h0);

    // Underflow with rready held low for 5 cycles
    axi_read(4'hC, 32'h0000_0000, "data_empty", 5, 1'b0, 24'h0);
    axi_read(4'h8, 32'h0009_0000, "status_unf", 0, 1'b0, 24'h0);
    check("irq_no_thresh", 32'(irq), 32'd0);

    // awvalid leads wvalid by 3 cycles
    axi_write(4'h4, 32'h0000_0201, 4'hF, "wr_aw_lead", 3, 1'b0, 24'h0);
    axi_read(4'h4, 32'h0000_0201, "ctrl_aw_lead", 0, 1'b0, 24'h0);

    // Reset asserted while a read response is pending
    araddr  = 4'h0;
    arvalid = 1'b1;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        if (arready) break;
        tick();
      end
      if (!arready) timeout("rst_mid_ar");
    end
    tick();
    arvalid = 1'b0;
    check("rst_mid_rvalid_pre", 32'(rvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_arready", 32'(arready), 32'd0);
    $display("rst asserted mid-read rvalid=%0b", rvalid);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    axi_read(4'h8, 32'h0001_0000, "status_after_rst", 0, 1'b0, 24'h0);
    axi_read(4'h0, 32'h0012_3456, "id_after_rst", 0, 1'b0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
